local_store: RTL and testbench

//  - Responder side of the odd-pipe local-store (LS) interface: the SPU local-store memory that the

---
 rtl/local_store.sv | 75 +++++++
 tb/tb_local_store.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/local_store.sv
// local_store: quadword local store with a data port and an instruction-fetch port, data priority, fixed-latency reads.
// Optional LS_STATS_EN adds saturating load/store/fetch-stall counters.
module local_store #(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ls_req_valid,
  input  logic              ls_req_write,
  input  logic [ADDR_W-1:0] ls_address_input,
  input  logic [127:0]      ls_wr_data_input,
  output logic [127:0]      ls_rd_data_output,
  output logic              ls_rd_valid,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_address_input,
  output logic              if_grant,
  output logic [127:0]      if_data_output,
  output logic              if_valid
`ifdef LS_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_if_stalls
`endif
);
  localparam int DEPTH = 2 ** (ADDR_W - 4);
  logic [127:0]       mem [DEPTH];
  logic [ADDR_W-5:0]  idx [2];
  logic [1:0]         acc;
  logic [LATENCY-1:0] v [2];
  logic [127:0]       d [2][LATENCY];
  logic               st, unused;
  assign unused   = ^{ls_address_input[3:0], if_address_input[3:0]};
  assign idx[0]   = ls_address_input[ADDR_W-1:4];
  assign idx[1]   = if_address_input[ADDR_W-1:4];
  assign if_grant = if_req & ~ls_req_valid & ~reset;
  assign st       = ls_req_valid & ls_req_write & ~reset;
  assign acc      = {if_grant, ls_req_valid & ~ls_req_write & ~reset};
  always_ff @(posedge clock)
    if (st) mem[idx[0]] <= ls_wr_data_input;
  // data stages only advance behind a valid, so the last stage holds the last delivered word
  always_ff @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        v[p] <= '0;
        for (int i = 0; i < LATENCY; i++) d[p][i] <= '0;
      end else begin
        v[p][0] <= acc[p];
        if (acc[p]) d[p][0] <= mem[idx[p]];
        for (int i = 1; i < LATENCY; i++) begin
          v[p][i] <= v[p][i-1];
          if (v[p][i-1]) d[p][i] <= d[p][i-1];
        end
      end
    end
  end
  assign ls_rd_valid       = v[0][LATENCY-1] & ~reset;
  assign ls_rd_data_output = d[0][LATENCY-1];
  assign if_valid          = v[1][LATENCY-1] & ~reset;
  assign if_data_output    = d[1][LATENCY-1];
`ifdef LS_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_loads     <= '0;
      stat_stores    <= '0;
      stat_if_stalls <= '0;
    end else begin
      if (acc[0] && stat_loads != '1) stat_loads <= stat_loads + 32'd1;
      if (st && stat_stores != '1) stat_stores <= stat_stores + 32'd1;
      if (if_req && !if_grant && stat_if_stalls != '1) stat_if_stalls <= stat_if_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_local_store.sv
// tb_local_store: random and directed traffic against a queue-based model of the local store.
module tb_local_store;
  localparam int L = 6;
  logic         clock = 0;
  logic         reset, ls_req_valid, ls_req_write, if_req;
  logic [14:0]  ls_address_input, if_address_input;
  logic [127:0] ls_wr_data_input, ls_rd_data_output, if_data_output;
  logic         ls_rd_valid, if_grant, if_valid;
`ifdef LS_STATS_EN
  logic [31:0]  stat_loads, stat_stores, stat_if_stalls;
  int           n_ld, n_st, n_stall;
`endif
  always #5 clock = ~clock;
  local_store dut (
    .clock(clock), .reset(reset),
    .ls_req_valid(ls_req_valid), .ls_req_write(ls_req_write),
    .ls_address_input(ls_address_input), .ls_wr_data_input(ls_wr_data_input),
    .ls_rd_data_output(ls_rd_data_output), .ls_rd_valid(ls_rd_valid),
    .if_req(if_req), .if_address_input(if_address_input), .if_grant(if_grant),
    .if_data_output(if_data_output), .if_valid(if_valid)
`ifdef LS_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_if_stalls(stat_if_stalls)
`endif
  );
  typedef struct { int due; logic [127:0] d; } rsp_t;
  rsp_t         lq[$], fq[$];
  logic [127:0] mm [2048];
  logic [127:0] ls_last, if_last;
  logic [10:0]  pool [16];
  int           cyc, total, bad;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic cycle();
    logic ev;
    @(negedge clock);
    ev = lq.size() > 0 && lq[0].due == cyc && !reset;
    check("ls_valid", ls_rd_valid, ev);
    if (ev) begin ls_last = lq[0].d; void'(lq.pop_front()); end
    check("ls_data", ls_rd_data_output, ls_last);
    ev = fq.size() > 0 && fq[0].due == cyc && !reset;
    check("if_valid", if_valid, ev);
    if (ev) begin if_last = fq[0].d; void'(fq.pop_front()); end
    check("if_data", if_data_output, if_last);
    check("if_grant", if_grant, if_req && !ls_req_valid && !reset);
`ifdef LS_STATS_EN
    check("stat_loads", stat_loads, n_ld);
    check("stat_stores", stat_stores, n_st);
    check("stat_stalls", stat_if_stalls, n_stall);
`endif
    @(posedge clock);
    if (reset) begin
      lq.delete(); fq.delete(); ls_last = '0; if_last = '0;
`ifdef LS_STATS_EN
      n_ld = 0; n_st = 0; n_stall = 0;
`endif
    end else begin
      if (ls_req_valid && ls_req_write) mm[ls_address_input[14:4]] = ls_wr_data_input;
      else if (ls_req_valid) lq.push_back('{cyc + L, mm[ls_address_input[14:4]]});
      else if (if_req) fq.push_back('{cyc + L, mm[if_address_input[14:4]]});
`ifdef LS_STATS_EN
      if (ls_req_valid && ls_req_write) n_st++;
      if (ls_req_valid && !ls_req_write) n_ld++;
      if (if_req && ls_req_valid) n_stall++;
`endif
    end
    cyc++;
    #1;
  endtask
  task automatic drive(input logic v, input logic w, input logic [14:0] a, input logic [127:0] wd,
                       input logic f, input logic [14:0] fa);
    ls_req_valid = v; ls_req_write = w; ls_address_input = a; ls_wr_data_input = wd;
    if_req = f; if_address_input = fa;
    cycle();
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, '0, '0, 0, '0);
  endtask
  initial begin
    total = 0; bad = 0; cyc = 0; ls_last = '0; if_last = '0;
`ifdef LS_STATS_EN
    n_ld = 0; n_st = 0; n_stall = 0;
`endif
    reset = 1; ls_req_valid = 0; ls_req_write = 0; if_req = 1;
    ls_address_input = '0; if_address_input = '0; ls_wr_data_input = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ls_valid", ls_rd_valid, 0);
    check("rst_ls_data", ls_rd_data_output, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_data", if_data_output, 0);
    check("rst_if_grant", if_grant, 0);
    reset = 0; if_req = 0;
    // store then load next cycle returns the new word after L cycles
    drive(1, 1, 15'h0040, 128'hDEAD_BEEF, 0, '0);
    drive(1, 0, 15'h0040, '0, 0, '0);
    idle(L);
    check("t1_data", ls_rd_data_output, 128'hDEAD_BEEF);
    // low nibble of the address is ignored
    drive(1, 1, 15'h0100, 128'd20, 0, '0);
    drive(1, 0, 15'h010F, '0, 0, '0);
    idle(L);
    check("t2_data", ls_rd_data_output, 128'd20);
    for (int i = 0; i < 16; i++) begin
      pool[i] = 11'($urandom);
      drive(1, 1, {pool[i], 4'($urandom)}, {$urandom, $urandom, $urandom, $urandom}, 0, '0);
    end
    // four back-to-back loads stream out in order
    for (int i = 0; i < 4; i++) drive(1, 0, {pool[i], 4'h0}, '0, 0, '0);
    idle(L + 1);
    check("t3_last", ls_rd_data_output, mm[pool[3]]);
    // fetch held while data port busy: granted only on the third cycle
    for (int k = 0; k < 3; k++) begin
      ls_req_valid = k < 2; ls_req_write = k == 0; ls_address_input = {pool[5], 4'h0};
      ls_wr_data_input = 128'h5A5A; if_req = 1; if_address_input = {pool[6], 4'h3};
      #1;
      check("t4_grant", if_grant, k == 2);
      cycle();
    end
    idle(L + 1);
    check("t4_if_data", if_data_output, mm[pool[6]]);
    // reset two cycles after a load drops it; contents persist
    drive(1, 0, {pool[7], 4'h0}, '0, 1, {pool[8], 4'h0});
    drive(0, 0, '0, '0, 1, {pool[8], 4'h0});
    reset = 1;
    drive(0, 0, '0, '0, 0, '0);
    reset = 0;
    idle(L + 2);
    check("t5_ls_data", ls_rd_data_output, 0);
    drive(1, 0, {pool[7], 4'h9}, '0, 0, '0);
    idle(L);
    check("t5_persist", ls_rd_data_output, mm[pool[7]]);
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 7));
      drive(r < 5, r < 2, {pool[$urandom_range(0, 15)], 4'($urandom)}, {$urandom, $urandom, $urandom, $urandom},
            1'($urandom), {pool[$urandom_range(0, 15)], 4'($urandom)});
    end
    idle(L + 2);
    check("drain_ls", lq.size(), 0);
    check("drain_if", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
